// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, DATA_BITS payload LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data and stop bits.
module uart_transmitter #(
  parameter int unsigned SAMPLES_PER_BIT = 16,
  parameter int unsigned DATA_BITS       = 8
) (
  input  logic                 tx_clk,
  input  logic                 reset,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned TICK_W = (SAMPLES_PER_BIT > 1) ? $clog2(SAMPLES_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                 state_q, state_d;
  logic [TICK_W-1:0]      tick_q, tick_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   serial_d, busy_d, done_d;
  logic                   tick_wrap_c;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  // State, counters and registered line outputs
  always_ff @(posedge tx_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_serial <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_serial <= serial_d;
      tx_busy   <= busy_d;
      tx_done   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tick_wrap_c = (tick_q == TICK_LAST);

  // Next state; outputs are derived from the next state so they register without extra latency
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    serial_d = 1'b1;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_start) begin
          shift_d  = tx_data;
          tick_d   = '0;
          bit_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
          state_d  = START;
        end
      end
      START: begin
        if (tick_wrap_c) begin
          tick_d  = '0;
          state_d = DATA;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      DATA: begin
        if (tick_wrap_c) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_wrap_c) begin
          tick_d  = '0;
          state_d = STOP;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
`endif
      STOP: begin
        // Requests arriving here, including on the done cycle, are dropped
        if (tick_wrap_c) begin
          tick_d  = '0;
          state_d = IDLE;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      default: begin
        tick_d  = '0;
        bit_d   = '0;
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:   serial_d = 1'b0;
      DATA:    serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_d = parity_d;
`endif
      default: serial_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (tick_d == TICK_LAST);
  end

endmodule
